cursor_controller: RTL
======================

# cursor_controller

Upstream stage of the cursor overlay. Converts five raw push-buttons into a cell-aligned cursor position, with frame-synchronous updates, and issues cell-toggle requests to the Game-of-Life grid store. Its `cursorX`/`cursorY` drive the plus-shaped cursor renderer. Its toggle handshake feeds the grid memory write port.

## Interface
Parameters:
- `H_RES`, 640, active pixels per line
- `V_RES`, 480, active lines
- `CELL_SIZE`, 8, pixels per cell edge; power of two
- `DEBOUNCE_CYCLES`, 250000, stable cycles required to accept a button level (10 ms at 25 MHz)
- `REPEAT_DELAY`, 12500000, hold cycles before the first auto-repeat step
- `REPEAT_RATE`, 2500000, cycles between subsequent auto-repeat steps

Derived values:
- `H_CELLS = H_RES/CELL_SIZE` (80); `V_CELLS = V_RES/CELL_SIZE` (60)

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous active-low reset
- `btnUp`, `btnDown`, `btnLeft`, `btnRight`, `btnSel`  in  1 each  raw, asynchronous, active-high buttons
- `frameStart`  in  1  one-cycle pulse at start of vertical blank
- `cursorX`  out  $clog2(H_RES)  cursor centre pixel column
- `cursorY`  out  $clog2(V_RES)  cursor centre pixel row
- `cellX`  out  $clog2(H_CELLS)  current cursor cell column
- `cellY`  out  $clog2(V_CELLS)  current cursor cell row
- `toggleValid`  out  1  toggle request pending
- `toggleX`  out  $clog2(H_CELLS)  latched cell column of the request
- `toggleY`  out  $clog2(V_CELLS)  latched cell row of the request
- `toggleReady`  in  1  grid store accepts the request

## Operation
- **Input conditioning.** Each button passes through a 2-FF synchronizer, then a debounce counter. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive cycles at the new synchronized value; any mismatch reloads the counter. A rising edge of the debounced level produces a one-cycle press pulse.
- **Auto-repeat.** Direction buttons only. A per-button hold FSM has three states:
  - IDLE → DELAY on press pulse.
  - DELAY → REPEAT after `REPEAT_DELAY` held cycles, emitting a step.
  - REPEAT emits a step every `REPEAT_RATE` cycles.
  - Any state → IDLE on debounced release.
- **Step accumulation.** Each step pulse sets a sticky pending flag per direction. Flags clear when applied at `frameStart`. Multiple steps of one direction within a frame collapse to one.
- **Position update.** Applied on `frameStart`. Up and down both pending cancel each other; left and right likewise. Movement wraps around the grid:
  - `cellX` 0 − 1 → `H_CELLS−1`; `H_CELLS−1` + 1 → 0.
  - `cellY` behaves the same with `V_CELLS`.
- **Pixel mapping.** `cursorX = cellX*CELL_SIZE + CELL_SIZE/2`; `cursorY` likewise. Both are registered and computed by shift.
- **Toggle handshake.**
  - A `btnSel` press pulse while `toggleValid`=0 sets `toggleValid`=1 and latches `toggleX`/`toggleY` from current `cellX`/`cellY`.
  - The request completes on a cycle with `toggleValid`&&`toggleReady`; `toggleValid` clears the next cycle.
  - Sel presses while a request is pending are dropped.
  - Cursor movement during a pending request leaves the latched coordinates unchanged.
  - A press on the completion cycle is dropped.
- **Reset.** Asynchronous, mid-operation included. It returns all counters, FSMs, pending flags and outputs to their reset values:
  - `cellX`=40, `cellY`=30, `cursorX`=324, `cursorY`=244
  - `toggleValid`=0, `toggleX`=0, `toggleY`=0
  - Debounced levels = 0

## Timing
- Raw edge to press pulse: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 cycle.
- Step pulse to position change: waits for the next `frameStart`. `cellX`/`cellY` update the cycle after `frameStart`; `cursorX`/`cursorY` update one cycle later.
- A step pulse coinciding with `frameStart` is applied at that frame.
- Press pulse to `toggleValid`=1: 1 cycle.
- `toggleValid`, `toggleX` and `toggleY` hold stable until accepted.

## Configuration
- `CURSOR_AUTOREPEAT_EN` defined: the hold FSM and repeat counters are present, as described above.
- Not defined: hold logic is removed. Each direction press pulse yields exactly one step; holding produces nothing further.

## Test plan
- Reset, then release: `cellX`=40, `cellY`=30, `cursorX`=324, `cursorY`=244, `toggleValid`=0.
- `btnRight` bouncing for 100 cycles, then stable for `DEBOUNCE_CYCLES`, then `frameStart` → `cellX`=41, `cursorX`=332. No step is registered during the bounce.
- Cursor at `cellX`=0 with one `btnLeft` press and `frameStart` → `cellX`=79, `cursorX`=636. Up and down pressed in the same frame → `cellY` unchanged.
- `btnSel` press at (41,30) with `toggleReady`=0 for 5 cycles:
  - `toggleValid`=1 holding `toggleX`=41, `toggleY`=30.
  - A second Sel press and a Right move during the wait leave the request unchanged.
  - `toggleReady`=1 → `toggleValid`=0 the next cycle.
- With `CURSOR_AUTOREPEAT_EN`, `btnDown` held for `REPEAT_DELAY+2*REPEAT_RATE`, `frameStart` after each step → `cellY` advances 30→34 (press, delay step, two repeat steps). Without the macro → `cellY`=31.
- `rst_n` asserted while `toggleValid`=1 and a step is pending → outputs return to reset values immediately. No move is applied at the next `frameStart`.

Source files
------------

// File: rtl/cursor_controller.sv
// Button-driven cell cursor for the Game-of-Life overlay: debounce, optional auto-repeat,
// frame-synchronous wrapping moves, and a valid/ready cell-toggle request.
// Build option: define CURSOR_AUTOREPEAT_EN to include the per-direction hold/repeat logic.
module cursor_controller #(
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int CELL_SIZE       = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 2500000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                btnUp,
  input  logic                                btnDown,
  input  logic                                btnLeft,
  input  logic                                btnRight,
  input  logic                                btnSel,
  input  logic                                frameStart,
  output logic [$clog2(H_RES)-1:0]            cursorX,
  output logic [$clog2(V_RES)-1:0]            cursorY,
  output logic [$clog2(H_RES/CELL_SIZE)-1:0]  cellX,
  output logic [$clog2(V_RES/CELL_SIZE)-1:0]  cellY,
  output logic                                toggleValid,
  output logic [$clog2(H_RES/CELL_SIZE)-1:0]  toggleX,
  output logic [$clog2(V_RES/CELL_SIZE)-1:0]  toggleY,
  input  logic                                toggleReady
);

  localparam int H_CELLS = H_RES / CELL_SIZE;
  localparam int V_CELLS = V_RES / CELL_SIZE;
  localparam int XW      = $clog2(H_RES);
  localparam int YW      = $clog2(V_RES);
  localparam int CXW     = $clog2(H_CELLS);
  localparam int CYW     = $clog2(V_CELLS);
  localparam int SH      = $clog2(CELL_SIZE);
  localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RST_CX  = H_CELLS / 2;
  localparam int RST_CY  = V_CELLS / 2;

  // Button order: 0 up, 1 down, 2 left, 3 right, 4 sel.
  logic [4:0]     raw;
  logic [4:0]     sync1_p0, sync2_p1;
  logic [4:0]     db_p2, db_d;
  logic [DBW-1:0] dcnt [5];
  logic [4:0]     press;
  logic [3:0]     step;
  logic [3:0]     pend;
  logic [3:0]     eff;

  assign raw = {btnSel, btnRight, btnLeft, btnDown, btnUp};

  function automatic logic [CXW-1:0] wrap_x(input logic [CXW-1:0] c,
                                            input logic inc, input logic dec);
    logic [CXW-1:0] r;
    r = c;
    if (inc && !dec)
      r = (c == CXW'(H_CELLS - 1)) ? '0 : c + 1'b1;
    else if (dec && !inc)
      r = (c == '0) ? CXW'(H_CELLS - 1) : c - 1'b1;
    return r;
  endfunction

  function automatic logic [CYW-1:0] wrap_y(input logic [CYW-1:0] c,
                                            input logic inc, input logic dec);
    logic [CYW-1:0] r;
    r = c;
    if (inc && !dec)
      r = (c == CYW'(V_CELLS - 1)) ? '0 : c + 1'b1;
    else if (dec && !inc)
      r = (c == '0) ? CYW'(V_CELLS - 1) : c - 1'b1;
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_p0 <= '0;
      sync2_p1 <= '0;
    end else begin
      sync1_p0 <= raw;
      sync2_p1 <= sync1_p0;
    end
  end

  // Stage p2: debounce; the level flips only after an unbroken run at the new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) dcnt[i] <= '0;
      db_p2 <= '0;
      db_d  <= '0;
    end else begin
      db_d <= db_p2;
      for (int i = 0; i < 5; i++) begin
        if (sync2_p1[i] == db_p2[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          dcnt[i]  <= '0;
          db_p2[i] <= sync2_p1[i];
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = db_p2 & ~db_d;

`ifdef CURSOR_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = $clog2(RMAX + 1);

  typedef enum logic [1:0] {HOLD_IDLE, HOLD_DELAY, HOLD_REPEAT} hold_t;

  hold_t          hold_q [4];
  hold_t          hold_d [4];
  logic [RCW-1:0] rcnt_q [4];
  logic [RCW-1:0] rcnt_d [4];
  logic [3:0]     hstep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        hold_q[i] <= HOLD_IDLE;
        rcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        hold_q[i] <= hold_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  always_comb begin
    hstep = '0;
    for (int i = 0; i < 4; i++) begin
      hold_d[i] = hold_q[i];
      rcnt_d[i] = rcnt_q[i];
      case (hold_q[i])
        HOLD_IDLE: begin
          if (press[i]) begin
            hold_d[i] = HOLD_DELAY;
            rcnt_d[i] = '0;
          end
        end
        HOLD_DELAY: begin
          if (!db_p2[i]) begin
            hold_d[i] = HOLD_IDLE;
          end else if (rcnt_q[i] == RCW'(REPEAT_DELAY - 1)) begin
            hstep[i]  = 1'b1;
            hold_d[i] = HOLD_REPEAT;
            rcnt_d[i] = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
          end
        end
        HOLD_REPEAT: begin
          if (!db_p2[i]) begin
            hold_d[i] = HOLD_IDLE;
          end else if (rcnt_q[i] == RCW'(REPEAT_RATE - 1)) begin
            hstep[i]  = 1'b1;
            rcnt_d[i] = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
          end
        end
        default: hold_d[i] = HOLD_IDLE;
      endcase
    end
  end

  assign step = press[3:0] | hstep;
`else
  assign step = press[3:0];
`endif

  // A step arriving on the frameStart cycle is folded into that frame's move.
  assign eff = pend | step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= '0;
      cellX <= CXW'(RST_CX);
      cellY <= CYW'(RST_CY);
    end else if (frameStart) begin
      pend  <= '0;
      cellX <= wrap_x(cellX, eff[3], eff[2]);
      cellY <= wrap_y(cellY, eff[1], eff[0]);
    end else begin
      pend <= pend | step;
    end
  end

  // Cell-to-pixel mapping: one register stage after the cell position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursorX <= XW'(RST_CX * CELL_SIZE + CELL_SIZE / 2);
      cursorY <= YW'(RST_CY * CELL_SIZE + CELL_SIZE / 2);
    end else begin
      cursorX <= (XW'(cellX) << SH) | XW'(CELL_SIZE / 2);
      cursorY <= (YW'(cellY) << SH) | YW'(CELL_SIZE / 2);
    end
  end

  // Completion has priority, so a Sel press on the accept cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggleValid <= 1'b0;
      toggleX     <= '0;
      toggleY     <= '0;
    end else if (toggleValid && toggleReady) begin
      toggleValid <= 1'b0;
    end else if (!toggleValid && press[4]) begin
      toggleValid <= 1'b1;
      toggleX     <= cellX;
      toggleY     <= cellY;
    end
  end

endmodule
